// File: rtl/pwm_fade_sequencer_if.sv
// pwm_fade_sequencer_if: control/status bundle between a fade controller and the sequencer.
// Latency: none, plain wires.
// Backpressure: none; start is a one-cycle request, stop a one-cycle abort.
interface pwm_fade_sequencer_if #(
    parameter int PRESCALE_W = 16
);
    logic                  start;
    logic                  stop;
    logic [PRESCALE_W-1:0] step_div;
    logic [7:0]            min_level;
    logic [7:0]            max_level;
    logic [7:0]            hold_steps;
    logic [7:0]            duty_cycle;
    logic                  busy;
    logic                  done;

    modport master (
        output start, stop, step_div, min_level, max_level, hold_steps,
        input  duty_cycle, busy, done
    );

    modport slave (
        input  start, stop, step_div, min_level, max_level, hold_steps,
        output duty_cycle, busy, done
    );
endinterface

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: ramps duty min->max, holds, ramps max->min, holds; PWM_FADE_LOOP_EN repeats until stop.
// Latency: busy rises one clk after start; duty_cycle moves one clk after each prescaler tick.
// Backpressure: none; start ignored while busy, stop aborts from any state on the next edge.
module pwm_fade_sequencer #(
    parameter int PRESCALE_W = 16
) (
    input logic                  clk,
    input logic                  reset,
    pwm_fade_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_HOLD_HIGH = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_HOLD_LOW  = 3'd4
    } state_t;

    state_t                r_state;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] r_step_div;
    logic [7:0]            r_min;
    logic [7:0]            r_max;
    logic [7:0]            r_hold;
    logic [7:0]            r_hold_cnt;
    logic [7:0]            r_duty;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_tick;
    logic                  w_hold_end;

    // A step happens when the prescaler reaches the latched divider; never while idle.
    assign w_tick     = (r_state != S_IDLE) && (r_presc == r_step_div);
    assign w_hold_end = (r_hold_cnt == r_hold);

    assign bus.duty_cycle = r_duty;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    // Step prescaler: free-runs 0..step_div while a sequence is active, parked at 0 otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (r_state == S_IDLE || bus.stop || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Sequencer FSM with registered duty/busy/done; stop takes priority over everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_step_div <= '0;
            r_min      <= '0;
            r_max      <= '0;
            r_hold     <= '0;
            r_hold_cnt <= '0;
            r_duty     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.stop) begin
                r_state    <= S_IDLE;
                r_duty     <= '0;
                r_busy     <= 1'b0;
                r_hold_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_step_div <= bus.step_div;
                            r_min      <= bus.min_level;
                            r_max      <= bus.max_level;
                            r_hold     <= bus.hold_steps;
                            r_duty     <= bus.min_level;
                            r_hold_cnt <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= S_RAMP_UP;
                        end
                    end
                    S_RAMP_UP: begin
                        if (w_tick) begin
                            // The 8'hFF guard keeps the level from wrapping regardless of max.
                            if (r_duty >= r_max || r_duty == 8'hFF) begin
                                r_state    <= S_HOLD_HIGH;
                                r_hold_cnt <= '0;
                            end else begin
                                r_duty <= r_duty + 8'd1;
                            end
                        end
                    end
                    S_HOLD_HIGH: begin
                        if (w_tick) begin
                            if (w_hold_end) begin
                                r_state <= S_RAMP_DOWN;
                            end else begin
                                r_hold_cnt <= r_hold_cnt + 8'd1;
                            end
                        end
                    end
                    S_RAMP_DOWN: begin
                        if (w_tick) begin
                            if (r_duty <= r_min || r_duty == 8'h00) begin
                                r_state    <= S_HOLD_LOW;
                                r_hold_cnt <= '0;
                            end else begin
                                r_duty <= r_duty - 8'd1;
                            end
                        end
                    end
                    S_HOLD_LOW: begin
                        if (w_tick) begin
                            if (w_hold_end) begin
                                r_done <= 1'b1;
`ifdef PWM_FADE_LOOP_EN
                                r_state <= S_RAMP_UP;
`else
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
`endif
                            end else begin
                                r_hold_cnt <= r_hold_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb_pwm_fade_sequencer: table vectors, random configs and corner sequences against a period model.
// Latency: inputs driven and outputs sampled 1 time unit after each rising clk edge.
// Backpressure: n/a.
module tb_pwm_fade_sequencer;

    localparam int PW = 16;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   exp_q[$];

    typedef struct {
        int sd;
        int mn;
        int mx;
        int hd;
        int exp_len;
        int exp_peak;
        int exp_final;
    } vec_t;

    vec_t tbl[6];

    pwm_fade_sequencer_if #(.PRESCALE_W(PW)) bus ();

    pwm_fade_sequencer #(.PRESCALE_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] obs();
        return {bus.busy, bus.done, bus.duty_cycle};
    endfunction

    task automatic set_cfg(input int sd, input int mn, input int mx, input int hd);
        bus.step_div   = PW'(sd);
        bus.min_level  = 8'(mn);
        bus.max_level  = 8'(mx);
        bus.hold_steps = 8'(hd);
    endtask

    task automatic scramble();
        bus.step_div   = PW'($urandom);
        bus.min_level  = 8'($urandom);
        bus.max_level  = 8'($urandom);
        bus.hold_steps = 8'($urandom);
    endtask

    // Expected duty per clk of one period: each step interval lasts sd+1 clks;
    // up-ramp visits min..top, holds top for hd+1 steps, down-ramp top..min, holds min for hd+1 steps.
    task automatic build_model(input int sd, input int mn, input int mx, input int hd);
        int top;
        exp_q.delete();
        top = (mn < mx) ? mx : mn;
        for (int v = mn; v <= top; v++) repeat (sd + 1) exp_q.push_back(v);
        repeat ((hd + 1) * (sd + 1)) exp_q.push_back(top);
        for (int v = top; v >= mn; v--) repeat (sd + 1) exp_q.push_back(v);
        repeat ((hd + 1) * (sd + 1)) exp_q.push_back(mn);
    endtask

    task automatic run_seq(input string tag, input int sd, input int mn, input int mx, input int hd,
                           input int nper, output int obs_len, output int obs_peak,
                           output int obs_final, output int done_cnt);
        int L;
        logic busy_end;
        build_model(sd, mn, mx, hd);
        L = exp_q.size();
`ifdef PWM_FADE_LOOP_EN
        busy_end = 1'b1;
`else
        busy_end = 1'b0;
`endif
        set_cfg(sd, mn, mx, hd);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        scramble();
        obs_len   = 0;
        obs_peak  = 0;
        obs_final = 0;
        done_cnt  = 0;
        for (int c = 0; c <= nper * L; c++) begin
            logic [9:0] want;
            if (c < nper * L)
                want = {1'b1, (c >= L && (c % L) == 0), 8'(exp_q[c % L])};
            else
                want = {busy_end, 1'b1, 8'(mn)};
            chk($sformatf("%s c%0d", tag, c), obs(), want);
            if (bus.busy && !bus.done) obs_len++;
            if (bus.done) done_cnt++;
            if (int'(bus.duty_cycle) > obs_peak) obs_peak = int'(bus.duty_cycle);
            obs_final = int'(bus.duty_cycle);
            if (c == 1) begin
                bus.start = 1'b1;
                scramble();
            end else if (c == 2) begin
                bus.start = 1'b0;
            end
            if (c < nper * L) tick();
        end
`ifdef PWM_FADE_LOOP_EN
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk({tag, " stop"}, obs(), 10'h000);
`else
        tick();
        chk({tag, " idle"}, obs(), {2'b00, 8'(mn)});
`endif
    endtask

    initial begin
        int ol, op, of, dc;
        int sd, mn, mx, hd;
        total = 0;
        bad   = 0;

        tbl[0] = '{0,   0,   3, 0, 10,   3,   0};
        tbl[1] = '{4,  10,  12, 0, 40,  12,  10};
        tbl[2] = '{0, 250, 255, 2, 18, 255, 250};
        tbl[3] = '{0,   5,   5, 0,  4,   5,   5};
        tbl[4] = '{1,   7,   3, 1, 12,   7,   7};
        tbl[5] = '{2,   0,   1, 3, 36,   1,   0};

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_cfg(0, 0, 0, 0);
        #2;
        chk("reset duty", 32'(bus.duty_cycle), 0);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset done", 32'(bus.done), 0);
        #10 reset = 1'b1;
        tick();
        chk("post reset idle", obs(), 10'h000);

        // Table vectors: measured busy length, peak, final level and done count.
        for (int k = 0; k < 6; k++) begin
            run_seq($sformatf("vec%0d", k), tbl[k].sd, tbl[k].mn, tbl[k].mx, tbl[k].hd, 1,
                    ol, op, of, dc);
            chk($sformatf("vec%0d len", k), ol, tbl[k].exp_len);
            chk($sformatf("vec%0d peak", k), op, tbl[k].exp_peak);
            chk($sformatf("vec%0d final", k), of, tbl[k].exp_final);
            chk($sformatf("vec%0d done_cnt", k), dc, 1);
            repeat (3) tick();
        end

        // Randomized configurations against the period model.
        for (int r = 0; r < 8; r++) begin
            sd = int'($urandom_range(0, 3));
            mn = int'($urandom_range(0, 255));
            hd = int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) mx = int'($urandom_range(0, 255));
            else mx = mn + int'($urandom_range(0, 6));
            if (mx > 255) mx = 255;
            run_seq($sformatf("rnd%0d", r), sd, mn, mx, hd, 1, ol, op, of, dc);
            chk($sformatf("rnd%0d done_cnt", r), dc, 1);
            repeat (2) tick();
        end

        // Stop during the down-ramp: idle next cycle, level 0, no done afterwards.
        set_cfg(0, 0, 3, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        chk("abort pre", obs(), {2'b10, 8'd2});
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("abort next", obs(), 10'h000);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("abort quiet c%0d", c), obs(), 10'h000);
        end

        // Start and stop together in idle: stop wins.
        set_cfg(0, 9, 20, 0);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("start+stop", obs(), 10'h000);
        tick();
        chk("start+stop later", obs(), 10'h000);

        // Asynchronous reset in the middle of the high hold.
        set_cfg(3, 0, 2, 2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (14) tick();
        chk("hold_high pre", obs(), {2'b10, 8'd2});
        #2 reset = 1'b0;
        #1 chk("async reset", obs(), 10'h000);
        #2 reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("after reset c%0d", c), obs(), 10'h000);
        end

`ifdef PWM_FADE_LOOP_EN
        // Three back-to-back periods, one done each, ended by stop.
        run_seq("loop", 0, 0, 2, 0, 3, ol, op, of, dc);
        chk("loop done_cnt", dc, 3);
        chk("loop len", ol, 22);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
